// File: rtl/rv32_mc_core_if.sv
// rv32_mc_core_if: shared instruction/data memory port of the core.
//   mem_addr  - byte address (fetch PC or load/store effective address)
//   mem_wdata - store data
//   mem_we    - 1 = write request
//   mem_valid - request valid; held with addr/we/wdata stable until mem_ready
//   mem_ready - request accepted; read data valid in the same cycle
//   mem_rdata - read data
// master = core side, slave = memory side.
interface rv32_mc_core_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_valid,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_addr, mem_wdata, mem_we, mem_valid,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/rv32_mc_core.sv
// rv32_mc_core: multi-cycle RV32I integer core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with a single valid/ready memory port and a trap-to-HALT mechanism.
// Ports:
//   clk_i        - rising-edge clock
//   rst_ni       - synchronous active-low reset
//   mem          - memory port (rv32_mc_core_if.master)
//   retire_o     - one-cycle pulse in the WB cycle of each completed instruction
//   halted_o     - core sits in HALT
//   halt_cause_o - 0 none, 1 ECALL, 2 EBREAK, 3 illegal, 4 misaligned PC, 5 misaligned data
//   dbg_pc_o     - current PC
module rv32_mc_core #(
  parameter int          PC_WIDTH = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rv32_mc_core_if.master      mem,
  output logic                retire_o,
  output logic                halted_o,
  output logic [2:0]          halt_cause_o,
  output logic [PC_WIDTH-1:0] dbg_pc_o
);
  localparam int RIW = $clog2(NUM_REGS);
  localparam logic [6:0] OPC_OP  = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LUI = 7'b0110111,
                         OPC_AUI = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BR  = 7'b1100011, OPC_LD  = 7'b0000011, OPC_ST  = 7'b0100011,
                         OPC_SYS = 7'b1110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cause_q, cause_d;
  logic                run_q;   // low for the cycle after a reset edge: keeps mem_valid off
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         ir_q, a_q, b_q, ld_q;
  logic [31:0]         rf_q [NUM_REGS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];
  assign rd  = ir_q[11:7];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];

  function automatic logic reg_bad(input logic [4:0] idx);
    return {1'b0, idx} >= 6'(NUM_REGS);
  endfunction

  // ---- decode legality: only the register fields an opcode actually uses are checked
  logic legal, use_rd, use_rs1, use_rs2, dec_ok;
  always_comb begin
    legal = 1'b0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    case (opc)
      OPC_OP:  begin
        legal  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_IMM: begin
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_LUI, OPC_AUI, OPC_JAL: begin legal = 1'b1; use_rd = 1'b1; end
      OPC_JALR: begin legal = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_BR:   begin legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LD:   begin legal = (f3 == 3'd2); use_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_ST:   begin legal = (f3 == 3'd2); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_SYS:  legal = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
      default:  legal = 1'b0;
    endcase
    dec_ok = legal && !(use_rd && reg_bad(rd)) && !(use_rs1 && reg_bad(rs1))
                   && !(use_rs2 && reg_bad(rs2));
  end

  // ---- execute: everything derives from ir_q/a_q/b_q/pc_q, which stay put through MEM and WB
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, op2, alu, npc, ea, wb_data, pc32;
  logic [4:0]  shamt;
  logic        take, wb_en;
  always_comb begin
    pc32  = 32'(pc_q);
    imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    imm_u = {ir_q[31:12], 12'b0};
    imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    op2   = (opc == OPC_OP) ? b_q : imm_i;
    shamt = (opc == OPC_OP) ? b_q[4:0] : ir_q[24:20];
    alu   = a_q + op2;
    case (f3)
      3'd0: if (opc == OPC_OP && ir_q[30]) alu = a_q - op2;
      3'd1: alu = a_q << shamt;
      3'd2: alu = {31'b0, $signed(a_q) < $signed(op2)};
      3'd3: alu = {31'b0, a_q < op2};
      3'd4: alu = a_q ^ op2;
      3'd5: if (ir_q[30]) alu = 32'($signed(a_q) >>> shamt);
            else          alu = a_q >> shamt;
      3'd6: alu = a_q | op2;
      3'd7: alu = a_q & op2;
    endcase
    case (f3)
      3'd0:    take = (a_q == b_q);
      3'd1:    take = (a_q != b_q);
      3'd4:    take = ($signed(a_q) < $signed(b_q));
      3'd5:    take = !($signed(a_q) < $signed(b_q));
      3'd6:    take = (a_q < b_q);
      3'd7:    take = !(a_q < b_q);
      default: take = 1'b0;
    endcase
    npc = pc32 + 32'd4;
    case (opc)
      OPC_JAL:  npc = pc32 + imm_j;
      OPC_JALR: npc = (a_q + imm_i) & ~32'd1;
      OPC_BR:   if (take) npc = pc32 + imm_b;
      default:  ;
    endcase
    case (opc)
      OPC_LUI:           wb_data = imm_u;
      OPC_AUI:           wb_data = pc32 + imm_u;
      OPC_JAL, OPC_JALR: wb_data = pc32 + 32'd4;
      OPC_LD:            wb_data = ld_q;
      default:           wb_data = alu;
    endcase
    wb_en = (opc != OPC_BR) && (opc != OPC_ST);
    ea    = a_q + ((opc == OPC_ST) ? imm_s : imm_i);
  end

  // ---- FSM next state and bus outputs
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    mem.mem_valid  = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = pc32;
    mem.mem_wdata  = 32'd0;
    case (state_q)
      S_FETCH: begin
        mem.mem_valid = run_q;
        if (run_q && mem.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_ok) state_d = S_EXEC;
        else begin state_d = S_HALT; cause_d = 3'd3; end
      end
      S_EXEC: begin
        if (opc == OPC_SYS) begin
          state_d = S_HALT; cause_d = ir_q[20] ? 3'd2 : 3'd1;
        end else if (opc == OPC_LD || opc == OPC_ST) begin
          if (ea[1:0] != 2'd0) begin state_d = S_HALT; cause_d = 3'd5; end
          else state_d = S_MEM;
        end else if (npc[1]) begin
          state_d = S_HALT; cause_d = 3'd4;
        end else state_d = S_WB;
      end
      S_MEM: begin
        mem.mem_valid = 1'b1;
        mem.mem_addr  = ea;
        mem.mem_we    = (opc == OPC_ST);
        mem.mem_wdata = (opc == OPC_ST) ? b_q : 32'd0;
        if (mem.mem_ready) state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      cause_q <= 3'd0;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC[PC_WIDTH-1:0];
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      run_q   <= 1'b1;
      if (state_q == S_WB) pc_q <= npc[PC_WIDTH-1:0];
    end
  end

  // datapath registers and register file carry no reset
  always_ff @(posedge clk_i) begin
    if (state_q == S_FETCH && mem.mem_valid && mem.mem_ready) ir_q <= mem.mem_rdata;
    if (state_q == S_DECODE) begin
      a_q <= (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[RIW-1:0]];
      b_q <= (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[RIW-1:0]];
    end
    if (state_q == S_MEM && mem.mem_ready && opc == OPC_LD) ld_q <= mem.mem_rdata;
    if (state_q == S_WB && wb_en && rd != 5'd0) rf_q[rd[RIW-1:0]] <= wb_data;
  end

  assign retire_o     = (state_q == S_WB);
  assign halted_o     = (state_q == S_HALT);
  assign halt_cause_o = cause_q;
  assign dbg_pc_o     = pc_q;
endmodule

// File: tb/tb_rv32_mc_core.sv
// tb_rv32_mc_core: directed table-driven bench for rv32_mc_core (NUM_REGS=16,
// RESET_PC=0x40). Each vector is a short program ending in a store of the
// result to 0x300 and an EBREAK (or a deliberate trap); the bench checks the
// halt cause, retire count, final PC and stored word. Hand-written sequences
// cover reset values, 4-cycle ALU timing, stalled SW/LW and reset mid-fetch.
module tb_rv32_mc_core;
  localparam logic [31:0] RPC  = 32'h40;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] ECAL = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic retire, halted;
  logic [2:0]  cause;
  logic [31:0] dbg_pc;
  logic [31:0] mem [256];

  rv32_mc_core_if mif ();
  rv32_mc_core #(.PC_WIDTH(32), .NUM_REGS(16), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem(mif),
    .retire_o(retire), .halted_o(halted), .halt_cause_o(cause), .dbg_pc_o(dbg_pc));

  always #5 clk = ~clk;
  assign mif.mem_ready = rdy;
  assign mif.mem_rdata = mem[mif.mem_addr[9:2]];
  always @(posedge clk)
    if (mif.mem_valid && mif.mem_ready && mif.mem_we) mem[mif.mem_addr[9:2]] = mif.mem_wdata;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- instruction encoders
  function automatic logic [31:0] f_i(input logic [31:0] im, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] f_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] f_s(input logic [31:0] im, input int rs2, input int rs1);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] f_b(input logic [31:0] im, input int rs2, input int rs1, input int f3);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] im, input int rd);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] f_u(input logic [31:0] im20, input int rd, input logic [6:0] op);
    return {im20[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input logic [31:0] im);
    return f_i(im, rs1, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] sw_res(input int rs2);
    return f_s(32'h300, rs2, 0);
  endfunction

  // ---- vector table
  typedef struct {
    string       name;
    int          n;
    logic [31:0] prog [16];
    logic [2:0]  cause;
    int          retires;
    logic [31:0] pc;
    logic [31:0] value;
  } vec_t;
  vec_t        vecs[$];
  logic [31:0] pq[$];

  task automatic add(input string nm, input logic [2:0] c, input int r, input logic [31:0] pc, input logic [31:0] v);
    vec_t t;
    t.name = nm; t.n = pq.size();
    for (int i = 0; i < 16; i++) t.prog[i] = (i < pq.size()) ? pq[i] : 32'h0;
    t.cause = c; t.retires = r; t.pc = pc; t.value = v;
    vecs.push_back(t);
    pq.delete();
  endtask

  task automatic load_and_reset(input vec_t v);
    rst_n = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < v.n; i++) mem[16 + i] = v.prog[i];
    mem[8'hC0] = SENT;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int ret, cyc;
    load_and_reset(v);
    ret = 0; cyc = 0;
    while (!halted && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (retire) ret++;
    end
    chk({v.name, " halted"}, 32'(halted), 32'd1);
    chk({v.name, " cause"}, 32'(cause), 32'(v.cause));
    chk({v.name, " retires"}, ret, v.retires);
    chk({v.name, " pc"}, dbg_pc, v.pc);
    chk({v.name, " value"}, mem[8'hC0], v.value);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rt[3];
    int nr, cyc, left, epi;
    logic in_stall, cap_we;
    logic [31:0] cap_wd;

    // ---- table
    pq = '{addi(1,0,5), addi(2,1,-7), sw_res(2), EBRK};
    add("addi_neg", 3'd2, 3, 32'h4C, 32'hFFFF_FFFE);
    pq = '{addi(1,0,5), addi(2,1,-7), f_r(32,2,1,0,3), sw_res(3), EBRK};
    add("sub", 3'd2, 4, 32'h50, 32'd7);
    pq = '{addi(2,0,-2), f_i(32'h401,2,5,4,7'h13), sw_res(4), EBRK};
    add("srai", 3'd2, 3, 32'h4C, 32'hFFFF_FFFF);
    pq = '{addi(2,0,-2), f_i(32'h001,2,5,5,7'h13), sw_res(5), EBRK};
    add("srli", 3'd2, 3, 32'h4C, 32'h7FFF_FFFF);
    pq = '{addi(1,0,5), addi(2,0,-2), f_r(0,1,2,2,6), sw_res(6), EBRK};
    add("slt", 3'd2, 4, 32'h50, 32'd1);
    pq = '{addi(1,0,5), addi(2,0,-2), f_r(0,1,2,3,7), sw_res(7), EBRK};
    add("sltu", 3'd2, 4, 32'h50, 32'd0);
    pq = '{addi(0,0,1), sw_res(0), EBRK};
    add("x0", 3'd2, 2, 32'h48, 32'd0);
    pq = '{f_u(32'h12345,1,7'h37), addi(1,1,32'h678), sw_res(1), EBRK};
    add("lui", 3'd2, 3, 32'h4C, 32'h1234_5678);
    pq = '{f_u(32'h1,3,7'h17), sw_res(3), EBRK};
    add("auipc", 3'd2, 2, 32'h48, 32'h1040);
    pq = '{addi(1,0,32'hF0), f_i(32'hFF,1,4,2,7'h13), f_i(32'h4,2,1,3,7'h13),
           f_r(0,2,3,6,4), f_r(0,1,4,7,5), f_r(0,5,4,0,6), sw_res(6), EBRK};
    add("logic", 3'd2, 7, 32'h5C, 32'h1EF);
    pq = '{f_j(32'd8,1), addi(1,0,99), sw_res(1), EBRK};
    add("jal", 3'd2, 2, 32'h4C, 32'h44);
    pq = '{addi(2,0,32'h51), f_i(32'd0,2,0,3,7'h67), addi(3,0,99), addi(3,0,98), sw_res(3), EBRK};
    add("jalr_odd", 3'd2, 3, 32'h54, 32'h48);
    pq = '{addi(1,0,3), addi(2,0,0), addi(2,2,1), addi(1,1,-1), f_b(-8,0,1,1), sw_res(2), EBRK};
    add("bne_loop", 3'd2, 12, 32'h58, 32'd3);
    pq = '{addi(1,0,-1), addi(2,0,1), addi(3,0,0), f_b(8,2,1,6), addi(3,3,1),
           f_b(8,2,1,5), addi(3,3,2), f_b(8,2,1,4), addi(3,3,4), sw_res(3), EBRK};
    add("branches", 3'd2, 9, 32'h68, 32'd3);
    pq = '{addi(1,0,1), 32'h0000_007F};
    add("illegal_op", 3'd3, 1, 32'h44, SENT);
    pq = '{f_i(32'd2,0,2,1,7'h03)};
    add("lw_misalign", 3'd5, 0, 32'h40, SENT);
    pq = '{f_r(0,2,1,0,17)};
    add("reg17", 3'd3, 0, 32'h40, SENT);
    pq = '{ECAL};
    add("ecall", 3'd1, 0, 32'h40, SENT);
    pq = '{addi(1,0,7), f_j(32'd6,1)};
    add("jal_misalign", 3'd4, 1, 32'h44, SENT);

    // ---- reset values (core held in reset)
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst mem_valid", 32'(mif.mem_valid), 32'd0);
    chk("rst mem_we", 32'(mif.mem_we), 32'd0);
    chk("rst mem_wdata", mif.mem_wdata, 32'd0);
    chk("rst retire", 32'(retire), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst cause", 32'(cause), 32'd0);
    chk("rst pc", dbg_pc, RPC);

    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- ALU timing: first retire 4 cycles after release, then every 4
    load_and_reset(vecs[1]);
    @(posedge clk); #1;
    chk("first fetch valid", 32'(mif.mem_valid), 32'd1);
    chk("first fetch addr", mif.mem_addr, RPC);
    nr = 0; cyc = 1;
    rt = '{-100, -100, -100};
    while (nr < 3 && cyc < 100) begin
      if (retire) begin rt[nr] = cyc; nr++; end
      if (nr < 3) begin @(posedge clk); #1; cyc++; end
    end
    chk("alu first retire", rt[0], 4);
    chk("alu retire gap1", rt[1] - rt[0], 4);
    chk("alu retire gap2", rt[2] - rt[1], 4);

    // ---- SW/LW with 3 stall cycles each on the data access to 0x8
    pq = '{addi(1,0,5), f_s(32'd8,1,0), f_i(32'd8,0,2,8,7'h03), sw_res(8), EBRK};
    add("swlw", 3'd2, 4, 32'h50, 32'd5);
    load_and_reset(vecs[vecs.size()-1]);
    nr = 0; cyc = 0; left = 0; epi = 0; in_stall = 1'b0; cap_we = 1'b0; cap_wd = 32'h0;
    rt = '{-100, -100, -100};
    while (!halted && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (retire) begin
        if (nr >= 1 && nr <= 3) rt[nr-1] = cyc;
        nr++;
      end
      if (mif.mem_valid && mif.mem_addr == 32'h8) begin
        if (!in_stall) begin
          in_stall = 1'b1; left = 3; epi++;
          cap_we = mif.mem_we; cap_wd = mif.mem_wdata;
          chk("mem we", 32'(cap_we), (epi == 1) ? 32'd1 : 32'd0);
          if (epi == 1) chk("sw wdata", cap_wd, 32'd5);
        end else begin
          chk("stall addr", mif.mem_addr, 32'h8);
          chk("stall we", 32'(mif.mem_we), 32'(cap_we));
          chk("stall wdata", mif.mem_wdata, cap_wd);
        end
        if (left > 0) begin rdy = 1'b0; left--; end
        else rdy = 1'b1;
      end else begin
        in_stall = 1'b0; rdy = 1'b1;
      end
    end
    rdy = 1'b1;
    chk("swlw halted", 32'(halted), 32'd1);
    chk("sw cycles", rt[0] - 4, 8);
    chk("lw cycles", rt[1] - rt[0], 8);
    chk("sw mem", mem[2], 32'd5);
    chk("lw x8", mem[8'hC0], 32'd5);

    // ---- reset asserted during a stalled fetch
    pq = '{addi(1,0,1), addi(1,0,2), addi(1,0,3), EBRK};
    add("rst_mid", 3'd2, 3, 32'h4C, SENT);
    load_and_reset(vecs[vecs.size()-1]);
    nr = 0; cyc = 0;
    while (nr < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (retire) nr++;
    end
    rdy = 1'b0;
    @(posedge clk); #1;
    chk("stall fetch valid", 32'(mif.mem_valid), 32'd1);
    chk("stall fetch addr", mif.mem_addr, 32'h48);
    @(posedge clk); #1;
    chk("stall fetch hold", mif.mem_addr, 32'h48);
    chk("pc before rst", dbg_pc, 32'h48);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst mid valid", 32'(mif.mem_valid), 32'd0);
    chk("rst mid pc", dbg_pc, RPC);
    rst_n = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    chk("refetch valid", 32'(mif.mem_valid), 32'd1);
    chk("refetch addr", mif.mem_addr, RPC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_mc_core.md
# rv32_mc_core

Parametrised multi-cycle RV32I integer core, the successor to the current fetch/decode skeleton. It executes the RV32I base subset (OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, word LW/SW, ECALL/EBREAK) through an explicit state machine. It talks to a single shared instruction/data memory over a valid/ready handshake. It adds configurable register count, PC width, and reset vector, plus a trap/halt mechanism that the skeleton lacks.

## Interface
- PC_WIDTH, 32: implemented PC bits (12..32); upper mem_addr bits are zero.
- NUM_REGS, 32: 32 (RV32I) or 16 (RV32E-style); any register index ≥ NUM_REGS is illegal.
- RESET_PC, 0: PC value loaded on reset; word aligned.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low (core held in reset while rst=0 at a clk edge).
- mem_addr  out  32  byte address: fetch PC or load/store effective address.
- mem_wdata  out  32  store data.
- mem_we  out  1  1 = write request.
- mem_valid  out  1  request valid.
- mem_ready  in  1  request accepted; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped in HALT.
- halt_cause  out  3  0 none, 1 ECALL, 2 EBREAK, 3 illegal instr, 4 misaligned fetch target, 5 misaligned data addr.
- dbg_pc  out  PC_WIDTH  current PC.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_valid=1, mem_we=0, mem_addr=pc. On mem_valid&&mem_ready, latch mem_rdata into the instruction register and go to DECODE.
- DECODE: check opcode and funct3/funct7 legality plus register indices. Illegal → HALT with cause 3. Otherwise latch rs1/rs2 values into operand regs, then go to EXEC.
- EXEC:
  - ALU ops: funct3 0 ADD/SUB (SUB only for OP with inst[30]=1), 1 SLL, 2 SLT signed, 3 SLTU, 4 XOR, 5 SRL/SRA (inst[30]), 6 OR, 7 AND. Shift amount is operand[4:0] for OP and inst[24:20] for OP-IMM.
  - Immediate formats follow I, S, B, U, J encodings, all sign-extended to 32 bits.
  - Branches BEQ/BNE/BLT/BGE/BLTU/BGEU. Taken target = pc+Bimm.
  - JAL target = pc+Jimm. JALR target = (rs1+Iimm) & ~1.
  - Any new PC with bit1 set → HALT with cause 4; PC and registers are left unchanged.
  - Load/store: effective address = rs1 + imm. addr[1:0]≠0 → HALT with cause 5. Otherwise go to MEM.
  - ECALL → HALT cause 1; EBREAK → HALT cause 2.
  - All other instructions go to WB.
- MEM: mem_valid=1, mem_addr=EA; mem_we=1 and mem_wdata=rs2 for SW. On handshake, LW captures mem_rdata; then go to WB.
- WB: write the result to rd unless rd=0 (x0 reads 0 always). Set pc to the next PC (pc+4 or target), truncated to PC_WIDTH. Pulse retire. Go to FETCH.
- HALT: absorbing state; only reset exits. The faulting instruction does not retire.
- Register file: the target is plain flops/LUT-RAM. Registers are not reset, except that x0 reads 0.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, mem_valid=0 during reset, mem_we=0, mem_wdata=0, retire=0, halted=0, halt_cause=0.
- First fetch request is in the first cycle after rst returns to 1.
- mem_addr, mem_we, and mem_wdata are held stable while mem_valid=1 and mem_ready=0. mem_valid never drops before the handshake.
- mem_valid=0 in DECODE, EXEC, WB, and HALT.
- Zero-wait latency (mem_ready tied 1): ALU/branch/jump/LUI/AUIPC take 4 cycles (FETCH, DECODE, EXEC, WB); LW/SW take 5.
- Each cycle of mem_ready=0 adds one cycle to FETCH or MEM.
- retire is asserted in the WB cycle; dbg_pc updates on the edge ending WB.
- halted rises on the edge leaving EXEC/DECODE into HALT.
- Reset mid-handshake: mem_valid is 0 in the cycle after the reset edge, and any pending request is abandoned.
- Arithmetic wraps modulo 2^32. PC wraps modulo 2^PC_WIDTH.

## Test plan
- ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2, with mem_ready=1 → x2=0xFFFFFFFE, x3=7, retire every 4 cycles.
- SRAI x4,x2,1 and SRLI x5,x2,1 → x4=0xFFFFFFFF, x5=0x7FFFFFFF; SLT x6,x2,x1=1 and SLTU x7,x2,x1=0.
- Loop: BNE countdown from 3 → body retires 3 times, final PC = loop exit. JAL x1,+8 → x1=pc+4. JALR with odd rs1 clears bit0.
- SW x1,8(x0) then LW x8,8(x0) with mem_ready low for 3 cycles → addr/wdata stable through stalls, x8=5, 8-cycle instruction.
- ADDI x0,x0,1 → x0 reads 0. Opcode 0x7F → halted=1, cause 3, no retire. LW at addr 0x2 → cause 5.
- NUM_REGS=16: ADD x17,... → cause 3. Assert rst=0 during a stalled fetch → mem_valid=0 next cycle, pc=RESET_PC.
